cga_mac_segpt_ldctl: RTL
========================

Name: cga_mac_segpt_ldctl

Overview:
Load controller for the MAC segment/page-table register group (PCR, SEG, EXM).
- Arbitrates between two requesters and turns each grant into a single-cycle load strobe plus registered data on the FIDBO bus:
  - microcode: single-register loads;
  - context-restore engine: an atomic PCR→SEG→EXM word sequence.
- Sits between the microcode decode / context-switch logic and the SEGPT register block.
- Generates LLDPCR, LLDSEG and LLDEXM.

Parameters:
- DW, 16: FIDBO/data width.
- CR_WORDS, 3: context-restore sequence length. 3 = PCR, SEG, EXM; 2 = PCR, SEG only (EXM step skipped).

Ports:
- MCLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- UC_REQ  in  1  microcode load request; level, held until UC_ACK.
- UC_SEL  in  2  target: 00 PCR, 01 SEG, 10 EXM, 11 reserved.
- UC_DATA  in  DW  microcode load data.
- UC_ACK  out  1  one-cycle grant/complete pulse.
- CR_START  in  1  one-cycle pulse; requests a context-restore sequence.
- CR_VALID  in  1  restore word valid.
- CR_DATA  in  DW  restore word.
- CR_READY  out  1  controller accepts a restore word this cycle.
- CR_DONE  out  1  one-cycle pulse, issued with the last strobe.
- FIDBO_15_0  out  DW  registered load data to SEGPT.
- LLDPCR  out  1  PCR load strobe.
- LLDSEG  out  1  SEG load strobe.
- LLDEXM  out  1  EXM load strobe.
- BUSY  out  1  high whenever state is not IDLE or a CR start is pending.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cr_pend=0.
  - FIDBO_15_0=0; LLDPCR, LLDSEG, LLDEXM, UC_ACK, CR_DONE = 0.
  - CR_READY=0, BUSY=0.
- Reset mid-sequence:
  - The sequence is abandoned with no further strobes and no CR_DONE.
  - Registers already loaded stay loaded.
- States:
  - IDLE: no grant in progress.
  - UC_GAP: one-cycle lockout after a microcode grant.
  - CR_PCR, CR_SEG, CR_EXM: context-restore word steps.
- Strobes and UC_ACK/CR_DONE are registered one-cycle pulses. FIDBO_15_0 updates on the same edge and holds its value until the next grant.
- At most one strobe is high in any cycle.
- IDLE transitions:
  - CR_START or cr_pend set, and no UC_REQ → CR_PCR; cr_pend cleared.
  - UC_REQ (takes priority over a CR start), at the next edge:
    - FIDBO ← UC_DATA;
    - the strobe selected by UC_SEL pulses;
    - UC_ACK=1; state → UC_GAP.
  - UC_SEL=11: UC_ACK still pulses, no strobe, FIDBO unchanged.
  - CR_START arriving while UC is served, in UC_GAP, or during a CR sequence sets cr_pend. Repeated starts collapse into one.
- UC_GAP → IDLE unconditionally. UC_REQ is ignored here, so a requester that drops UC_REQ on UC_ACK is never double-served.
- CR states:
  - CR_READY = 1 combinationally in CR_PCR/CR_SEG/CR_EXM; 0 otherwise.
  - On CR_VALID & CR_READY, at the next edge: FIDBO ← CR_DATA and the step's strobe pulses.
  - Transitions: CR_PCR→CR_SEG; CR_SEG→CR_EXM, or → IDLE with CR_DONE when CR_WORDS=2; CR_EXM→IDLE with CR_DONE.
  - CR_VALID low stalls the sequence indefinitely, with no strobes.
- Atomicity: UC_REQ is not granted while in any CR state; UC_ACK stays low.
- Throughput:
  - UC: one grant per 2 cycles.
  - CR: one word per cycle, 3 cycles best case.

Optional Feature:
SEGPT_LDCTL_SHADOW_EN
- Defined:
  - Adds outputs SH_PCR[DW-1:0], SH_SEG[7:0] and SH_EXM[2:0].
  - Each updates on the same edge as its strobe, from the data being loaded (SEG from bits 7:0, EXM from bits 2:0).
  - All reset to 0.
  - These give readback without an extra SEGPT read path.
- Undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cga_mac_pkg:
  - state enum (IDLE, UC_GAP, CR_PCR, CR_SEG, CR_EXM);
  - UC_SEL encodings (SEL_PCR, SEL_SEG, SEL_EXM, SEL_RSVD);
  - SEG_W=8, EXM_W=3.
- One sub-module is natural: cga_mac_segpt_ldctl_strb, the registered strobe/FIDBO output stage (takes grant, target and data). The FSM/arbiter stays in the top module.

Test Plan:
- Reset, then UC_REQ with UC_SEL=01, UC_DATA=0x00A5 → next edge: FIDBO=0x00A5, LLDSEG=1 for one cycle, UC_ACK=1. UC_REQ still held one more cycle gives no second grant.
- CR_START, then words 0x8123, 0x0042, 0x0005 presented back-to-back with CR_VALID=1 → LLDPCR, LLDSEG, LLDEXM on consecutive cycles with matching FIDBO. CR_DONE coincides with LLDEXM. BUSY drops the cycle after.
- CR_START and UC_REQ (SEL=00, 0x1234) in the same cycle → PCR load 0x1234 with UC_ACK first; the CR sequence begins 2 cycles later.
- UC_REQ raised in CR_SEG with CR_VALID deasserted for 5 cycles → no strobes and no UC_ACK during the stall. UC is served only after CR_DONE.
- RESET asserted asynchronously between LLDPCR and LLDSEG of a sequence → all outputs 0 immediately; no later strobes or CR_DONE; cr_pend cleared.
- UC_SEL=11 → UC_ACK pulses, no strobe, FIDBO keeps its previous value. With CR_WORDS=2, the sequence ends after LLDSEG with CR_DONE.

Source files
------------

// File: rtl/cga_mac_pkg.sv
// Shared types and encodings for the MAC segment/page-table load controller.
package cga_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UC_GAP,
        CR_PCR,
        CR_SEG,
        CR_EXM
    } state_t;

    localparam logic [1:0] SEL_PCR  = 2'b00;
    localparam logic [1:0] SEL_SEG  = 2'b01;
    localparam logic [1:0] SEL_EXM  = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    localparam int SEG_W = 8;
    localparam int EXM_W = 3;

endpackage

// File: rtl/cga_mac_segpt_ldctl_strb.sv
// Registered load-strobe / FIDBO output stage; one strobe per grant at most.
// SEGPT_LDCTL_SHADOW_EN adds readback shadow copies of the loaded values.
module cga_mac_segpt_ldctl_strb
    import cga_mac_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          grant,
    input  logic [1:0]    tgt,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] fidbo,
    output logic          ld_pcr,
    output logic          ld_seg,
    output logic          ld_exm
`ifdef SEGPT_LDCTL_SHADOW_EN
    ,
    output logic [DW-1:0]    sh_pcr,
    output logic [SEG_W-1:0] sh_seg,
    output logic [EXM_W-1:0] sh_exm
`endif
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fidbo  <= '0;
            ld_pcr <= 1'b0;
            ld_seg <= 1'b0;
            ld_exm <= 1'b0;
        end else begin
            ld_pcr <= grant && (tgt == SEL_PCR);
            ld_seg <= grant && (tgt == SEL_SEG);
            ld_exm <= grant && (tgt == SEL_EXM);
            // A reserved-target grant is acknowledged but leaves the bus alone.
            if (grant && (tgt != SEL_RSVD))
                fidbo <= data;
        end
    end

`ifdef SEGPT_LDCTL_SHADOW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_pcr <= '0;
            sh_seg <= '0;
            sh_exm <= '0;
        end else if (grant) begin
            if (tgt == SEL_PCR) sh_pcr <= data;
            if (tgt == SEL_SEG) sh_seg <= data[SEG_W-1:0];
            if (tgt == SEL_EXM) sh_exm <= data[EXM_W-1:0];
        end
    end
`endif

endmodule

// File: rtl/cga_mac_segpt_ldctl.sv
// PCR/SEG/EXM load controller: arbitrates microcode loads vs. atomic context restore.
// Optional readback shadows enabled by SEGPT_LDCTL_SHADOW_EN.
module cga_mac_segpt_ldctl
    import cga_mac_pkg::*;
#(
    parameter int DW       = 16,
    parameter int CR_WORDS = 3
) (
    input  logic          MCLK,
    input  logic          RESET,
    input  logic          UC_REQ,
    input  logic [1:0]    UC_SEL,
    input  logic [DW-1:0] UC_DATA,
    output logic          UC_ACK,
    input  logic          CR_START,
    input  logic          CR_VALID,
    input  logic [DW-1:0] CR_DATA,
    output logic          CR_READY,
    output logic          CR_DONE,
    output logic [DW-1:0] FIDBO_15_0,
    output logic          LLDPCR,
    output logic          LLDSEG,
    output logic          LLDEXM,
    output logic          BUSY
`ifdef SEGPT_LDCTL_SHADOW_EN
    ,
    output logic [DW-1:0]    SH_PCR,
    output logic [SEG_W-1:0] SH_SEG,
    output logic [EXM_W-1:0] SH_EXM
`endif
);

    state_t        state, state_nxt;
    logic          cr_pend, cr_pend_nxt;
    logic          uc_go, cr_go, cr_step, cr_last, grant;
    logic [1:0]    tgt;
    logic [DW-1:0] ld_data;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            cr_pend <= 1'b0;
            UC_ACK  <= 1'b0;
            CR_DONE <= 1'b0;
        end else begin
            state   <= state_nxt;
            cr_pend <= cr_pend_nxt;
            UC_ACK  <= uc_go;
            CR_DONE <= cr_last;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (uc_go) state_nxt = UC_GAP;
                     else if (cr_go) state_nxt = CR_PCR;
            UC_GAP:  state_nxt = IDLE;
            CR_PCR:  if (CR_VALID) state_nxt = CR_SEG;
            CR_SEG:  if (CR_VALID) state_nxt = (CR_WORDS == 2) ? IDLE : CR_EXM;
            CR_EXM:  if (CR_VALID) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Starts that arrive while busy collapse into a single pending request.
        cr_pend_nxt = cr_go ? 1'b0 : (cr_pend | CR_START);
    end

    always_comb begin
        uc_go    = (state == IDLE) && UC_REQ;
        cr_go    = (state == IDLE) && !UC_REQ && (CR_START || cr_pend);
        CR_READY = (state == CR_PCR) || (state == CR_SEG) || (state == CR_EXM);
        cr_step  = CR_READY && CR_VALID;
        cr_last  = cr_step && ((state == CR_EXM) || ((state == CR_SEG) && (CR_WORDS == 2)));
        grant    = uc_go || cr_step;
        BUSY     = (state != IDLE) || cr_pend;
        tgt      = UC_SEL;
        ld_data  = UC_DATA;
        case (state)
            CR_PCR:  tgt = SEL_PCR;
            CR_SEG:  tgt = SEL_SEG;
            CR_EXM:  tgt = SEL_EXM;
            default: tgt = UC_SEL;
        endcase
        if (CR_READY)
            ld_data = CR_DATA;
    end

    cga_mac_segpt_ldctl_strb #(.DW(DW)) u_strb (
        .clk    (MCLK),
        .rst    (RESET),
        .grant  (grant),
        .tgt    (tgt),
        .data   (ld_data),
        .fidbo  (FIDBO_15_0),
        .ld_pcr (LLDPCR),
        .ld_seg (LLDSEG),
        .ld_exm (LLDEXM)
`ifdef SEGPT_LDCTL_SHADOW_EN
        ,
        .sh_pcr (SH_PCR),
        .sh_seg (SH_SEG),
        .sh_exm (SH_EXM)
`endif
    );

endmodule
